dlf_iir_param: RTL and testbench
================================

// Module: dlf_iir_param
// PURPOSE
//  Parametrised digital loop filter (next generation): order-N IIR on the phase-detector sample
//  stream, driving the DCO control word. Adds runtime coefficients via a double-buffered bank,
//  a bang-bang input mode, output saturation, hold/clear controls and a valid/ready handshake.
//  Uses one time-shared multiplier: one MAC per clock.
// PARAMETERS
//  ORDER    3   filter order N: b0..bN feed-forward taps, a1..aN feedback taps
//  IN_W     8   master_in width, signed
//  BB_MODE  0   1: master_in[0] is a bang-bang bit (1 -> +1, 0 -> -1); upper bits ignored
//  OUT_W    12  slave_out width, signed
//  B_W      13  b-coefficient width, signed, B_FRAC fraction bits
//  B_FRAC   11  b-coefficient fraction bits
//  A_W      21  a-coefficient width, signed, A_FRAC fraction bits
//  A_FRAC   19  a-coefficient fraction bits (A_FRAC >= B_FRAC)
//  ACC_W    48  accumulator width; no internal wrap for legal parameter sets
// PORTS
//  clk         in   1       clock
//  rstn        in   1       asynchronous active-low reset
//  master_in   in   IN_W    input sample, signed
//  in_valid    in   1       master_in valid
//  in_ready    out  1       block can accept a sample
//  slave_out   out  OUT_W   filtered output, registered, signed
//  out_valid   out  1       1-cycle pulse when slave_out updates
//  sat_flag    out  1       high with out_valid if this output was clamped
//  hold        in   1       freeze filter: samples consumed, no update
//  clr         in   1       synchronous clear of histories/output
//  coef_we     in   1       write coef_wdata to shadow bank
//  coef_addr   in   4       0..N -> b0..bN; N+1..2N -> a1..aN; others ignored
//  coef_wdata  in   A_W     coefficient; b uses low B_W bits
//  coef_commit in   1       copy shadow bank to active bank
// BEHAVIOUR
//  Reset (async): slave_out=0, out_valid=0, sat_flag=0, in_ready=1; state IDLE;
//   x/y histories, shadow and active banks, commit-pending flag all 0.
//  Filter: y[n] = sat( rnd( sum_k=0..N bk*x[n-k] - sum_k=1..N ak*y[n-k] ) ).
//   b products are shifted left by A_FRAC-B_FRAC; the sum is ACC_W signed.
//   rnd: add 2^(A_FRAC-1), then arithmetic shift right by A_FRAC (round half up).
//   sat: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; sat_flag=1 if clamped.
//   The y history stores the saturated value.
//  FSM IDLE -> MAC -> OUT -> IDLE. in_ready=1 only in IDLE.
//   IDLE: on in_valid&in_ready:
//    - hold=0: shift master_in into x history (sign-extended, or +-1 in BB_MODE); go MAC.
//    - hold=1: sample is dropped; no state change, no out_valid.
//   MAC: 2N+1 cycles, one product per cycle (b0..bN, then a1..aN), k counter 0..2N.
//   OUT: register slave_out and sat_flag, shift y history, pulse out_valid; -> IDLE.
//   Latency: sample accepted at edge T -> out_valid high in cycle T+2N+2 (8 cycles at N=3).
//   Throughput: one sample per 2N+3 cycles.
//  Coefficients: coef_we writes the shadow bank at any time.
//   coef_commit sets a pending flag; the copy happens on the first IDLE cycle, so the active
//   bank never changes mid-sample.
//   Commit and in_valid in the same IDLE cycle: the copy applies first; that sample uses the
//   new bank.
//   coef_we and coef_commit in the same cycle: the committed bank includes the write.
//  clr (priority below rstn, above all else): zeroes x/y histories, slave_out and sat_flag;
//   aborts any MAC; out_valid=0; -> IDLE. Coefficient banks and the pending flag are kept.
//  hold asserted mid-MAC has no effect on the sample in flight.
// TESTING
//  1 reset mid-MAC (rstn low 1 cycle) -> slave_out=0, out_valid=0, in_ready=1 immediately
//  2 b0=0x800, rest 0, commit; x=5 -> out_valid 8 cycles after accept, slave_out=5
//  3 b0=0x800, a1=-262144 (-0.5); x=64,0,0,0 -> slave_out=64,32,16,8
//  4 b0=0xFFF, a1=-524288 (-1.0); x=127 repeatedly -> ramps, clamps at 2047, sat_flag=1
//  5 BB_MODE=1, b0=0x800; master_in=1, then 0 -> slave_out=+1, then -1 (0xFFF)
//  6 commit mid-MAC -> current output uses old bank, next uses new; clr mid-MAC -> no out_valid, slave_out=0

Source files
------------

// File: rtl/dlf_iir_param.sv
// Order-N IIR loop filter driving the DCO word, one shared MAC per clock.
// Double-buffered runtime coefficients, bang-bang input option, saturation.
module dlf_iir_param #(
  parameter int ORDER   = 3,
  parameter int IN_W    = 8,
  parameter int BB_MODE = 0,
  parameter int OUT_W   = 12,
  parameter int B_W     = 13,
  parameter int B_FRAC  = 11,
  parameter int A_W     = 21,
  parameter int A_FRAC  = 19,
  parameter int ACC_W   = 48
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic signed [IN_W-1:0]  master_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] slave_out,
  output logic                    out_valid,
  output logic                    sat_flag,
  input  logic                    hold,
  input  logic                    clr,
  input  logic                    coef_we,
  input  logic [3:0]              coef_addr,
  input  logic [A_W-1:0]          coef_wdata,
  input  logic                    coef_commit
);

  localparam int NC  = 2 * ORDER + 1;
  localparam int KW  = $clog2(NC + 1);
  localparam int D_W = (IN_W > OUT_W) ? IN_W : OUT_W;
  localparam int P_W = A_W + D_W;
  localparam int SH  = A_FRAC - B_FRAC;

  localparam logic signed [ACC_W-1:0] HALF =
    ACC_W'(1) <<< (A_FRAC - 1);
  localparam logic signed [ACC_W-1:0] YMAX =
    (ACC_W'(1) <<< (OUT_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] YMIN =
    -(ACC_W'(1) <<< (OUT_W - 1));

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                  state, state_nxt;
  logic [KW-1:0]           k;
  logic signed [ACC_W-1:0] acc;
  logic [A_W-1:0]          shadow [NC];
  logic [A_W-1:0]          active [NC];
  logic [A_W-1:0]          sh_nxt [NC];
  logic                    pend;
  logic signed [IN_W-1:0]  xh [ORDER+1];
  logic signed [OUT_W-1:0] yh [ORDER];

  logic [A_W-1:0]          cword;
  logic signed [B_W-1:0]   bcoef;
  logic signed [A_W-1:0]   coef_op;
  logic signed [D_W-1:0]   dsel;
  logic                    is_b;
  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] rnd;
  logic signed [OUT_W-1:0] y_sat;
  logic                    sat;
  logic signed [IN_W-1:0]  x_in;
  logic                    take;
  logic                    copy;

  assign in_ready = (state == IDLE);
  assign take     = in_valid && in_ready && !hold;

  always_comb begin
    if (BB_MODE != 0)
      x_in = master_in[0] ? IN_W'(1) : {IN_W{1'b1}};
    else
      x_in = master_in;
  end

  // Operand select: k = 0..N walks b/x, k = N+1..2N walks a/y.
  always_comb begin
    cword = '0;
    dsel  = '0;
    is_b  = 1'b0;
    for (int i = 0; i < NC; i++)
      if (k == KW'(i)) cword = active[i];
    for (int i = 0; i <= ORDER; i++)
      if (k == KW'(i)) begin
        dsel = D_W'(xh[i]);
        is_b = 1'b1;
      end
    for (int i = 0; i < ORDER; i++)
      if (k == KW'(ORDER + 1 + i)) dsel = D_W'(yh[i]);
  end

  always_comb begin
    bcoef    = cword[B_W-1:0];
    coef_op  = is_b ? A_W'(bcoef) : $signed(cword);
    prod     = P_W'(coef_op) * P_W'(dsel);
    prod_ext = ACC_W'(prod);
    term     = is_b ? (prod_ext <<< SH) : -prod_ext;
  end

  always_comb begin
    rnd   = (acc + HALF) >>> A_FRAC;
    sat   = 1'b0;
    y_sat = rnd[OUT_W-1:0];
    if (rnd > YMAX) begin
      y_sat = YMAX[OUT_W-1:0];
      sat   = 1'b1;
    end else if (rnd < YMIN) begin
      y_sat = YMIN[OUT_W-1:0];
      sat   = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take) state_nxt = MAC;
      MAC:     if (k == KW'(NC - 1)) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      k         <= '0;
      acc       <= '0;
      slave_out <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
      for (int i = 0; i <= ORDER; i++) xh[i] <= '0;
      for (int i = 0; i < ORDER; i++) yh[i] <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      if (clr) begin
        k         <= '0;
        acc       <= '0;
        slave_out <= '0;
        sat_flag  <= 1'b0;
        for (int i = 0; i <= ORDER; i++) xh[i] <= '0;
        for (int i = 0; i < ORDER; i++) yh[i] <= '0;
      end else begin
        unique case (state)
          IDLE: if (take) begin
            xh[0] <= x_in;
            for (int i = 1; i <= ORDER; i++)
              xh[i] <= xh[i-1];
            k <= '0;
          end
          MAC: begin
            acc <= (k == '0) ? term : acc + term;
            k   <= k + KW'(1);
          end
          OUT: begin
            slave_out <= y_sat;
            sat_flag  <= sat;
            out_valid <= 1'b1;
            yh[0]     <= y_sat;
            for (int i = 1; i < ORDER; i++)
              yh[i] <= yh[i-1];
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NC; i++) sh_nxt[i] = shadow[i];
    if (coef_we)
      for (int i = 0; i < NC; i++)
        if (int'(coef_addr) == i) sh_nxt[i] = coef_wdata;
  end

  // Active bank only changes in IDLE so a sample never mixes banks.
  assign copy = (state == IDLE) && (pend || coef_commit);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend <= 1'b0;
      for (int i = 0; i < NC; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      shadow <= sh_nxt;
      if (copy) begin
        active <= sh_nxt;
        pend   <= 1'b0;
      end else if (coef_commit) begin
        pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dlf_iir_param.sv
// Directed bench for dlf_iir_param: impulse, decay, saturation,
// bang-bang mode, bank commit timing, hold and clear.
module tb_dlf_iir_param;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  master_in;
  logic        in_valid, hold, clr;
  logic        coef_we, coef_commit;
  logic [3:0]  coef_addr;
  logic [20:0] coef_wdata;
  logic        in_ready, out_valid, sat_flag;
  logic [11:0] slave_out;
  logic        bb_ready, bb_valid, bb_sat;
  logic [11:0] bb_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dlf_iir_param dut (
    .clk(clk), .rstn(rstn),
    .master_in(master_in), .in_valid(in_valid),
    .in_ready(in_ready), .slave_out(slave_out),
    .out_valid(out_valid), .sat_flag(sat_flag),
    .hold(hold), .clr(clr),
    .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .coef_commit(coef_commit)
  );

  dlf_iir_param #(.BB_MODE(1)) dut_bb (
    .clk(clk), .rstn(rstn),
    .master_in(master_in), .in_valid(in_valid),
    .in_ready(bb_ready), .slave_out(bb_out),
    .out_valid(bb_valid), .sat_flag(bb_sat),
    .hold(hold), .clr(clr),
    .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .coef_commit(coef_commit)
  );

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a,
                    input logic [20:0] d);
    coef_addr  = a;
    coef_wdata = d;
    coef_we    = 1'b1;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic commit();
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic accept(input logic [7:0] x);
    master_in = x;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [11:0] y,
                          output logic s,
                          output int lat);
    lat = 99;
    y   = 'x;
    s   = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (out_valid) begin
        lat = c;
        y   = slave_out;
        s   = sat_flag;
        break;
      end
    end
    if (lat == 99) chk("out_valid timeout", 16'(out_valid), 16'd1);
  endtask

  task automatic quiet(input string tag);
    int seen;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (out_valid) seen++;
    end
    chk(tag, 16'(seen), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [11:0] y;
  logic        s;
  int          lat;
  logic [7:0]  xs3 [4] = '{8'd64, 8'd0, 8'd0, 8'd0};
  int          e3  [4] = '{64, 32, 16, 8};
  int          e4  [10] = '{254, 508, 762, 1016, 1270,
                            1524, 1778, 2032, 2047, 2047};

  initial begin
    rstn = 1'b0; master_in = '0; in_valid = 1'b0;
    hold = 1'b0; clr = 1'b0; coef_we = 1'b0;
    coef_commit = 1'b0; coef_addr = '0; coef_wdata = '0;
    tick(); tick();
    chk("rst slave_out", 16'(slave_out), 16'd0);
    chk("rst out_valid", 16'(out_valid), 16'd0);
    chk("rst sat_flag", 16'(sat_flag), 16'd0);
    chk("rst in_ready", 16'(in_ready), 16'd1);
    rstn = 1'b1;
    tick();

    wr(4'd0, 21'h800);
    commit();
    accept(8'd5);
    chk("busy in_ready", 16'(in_ready), 16'd0);
    wait_out(y, s, lat);
    chk("impulse latency", 16'(lat), 16'd8);
    chk("impulse y", 16'(y), 16'd5);
    tick();
    chk("out_valid pulse", 16'(out_valid), 16'd0);

    accept(8'd7);
    tick(); tick(); tick();
    #2 rstn = 1'b0;
    #1;
    chk("midmac rst slave_out", 16'(slave_out), 16'd0);
    chk("midmac rst out_valid", 16'(out_valid), 16'd0);
    chk("midmac rst in_ready", 16'(in_ready), 16'd1);
    tick();
    rstn = 1'b1;
    tick();

    wr(4'd0, 21'h800);
    wr(4'd4, 21'h1C0000);
    commit();
    for (int i = 0; i < 4; i++) begin
      accept(xs3[i]);
      wait_out(y, s, lat);
      chk($sformatf("decay y%0d", i), 16'(y), 16'(e3[i]));
    end

    clr_pulse();
    chk("clr slave_out", 16'(slave_out), 16'd0);
    wr(4'd0, 21'hFFF);
    wr(4'd4, 21'h180000);
    commit();
    for (int i = 0; i < 10; i++) begin
      accept(8'd127);
      wait_out(y, s, lat);
      chk($sformatf("ramp y%0d", i), 16'(y), 16'(e4[i]));
      chk($sformatf("ramp sat%0d", i), 16'(s),
          (i >= 8) ? 16'd1 : 16'd0);
    end

    clr_pulse();
    chk("clr sat_flag", 16'(sat_flag), 16'd0);
    wr(4'd0, 21'h800);
    wr(4'd4, 21'h0);
    commit();
    accept(8'd1);
    wait_out(y, s, lat);
    chk("bb +1", 16'(bb_out), 16'h001);
    chk("lin +1", 16'(y), 16'h001);
    accept(8'd0);
    wait_out(y, s, lat);
    chk("bb -1", 16'(bb_out), 16'hFFF);
    chk("lin 0", 16'(y), 16'h000);
    accept(8'hFE);
    wait_out(y, s, lat);
    chk("bb upper ignored", 16'(bb_out), 16'hFFF);
    chk("lin -2", 16'(y), 16'hFFE);

    clr_pulse();
    accept(8'd10);
    tick(); tick();
    coef_addr = 4'd0; coef_wdata = 21'h400;
    coef_we = 1'b1; coef_commit = 1'b1;
    tick();
    coef_we = 1'b0; coef_commit = 1'b0;
    wait_out(y, s, lat);
    chk("midmac commit old bank", 16'(y), 16'd10);
    accept(8'd10);
    wait_out(y, s, lat);
    chk("after commit new bank", 16'(y), 16'd5);

    wr(4'd0, 21'h800);
    master_in = 8'd6; in_valid = 1'b1; coef_commit = 1'b1;
    tick();
    in_valid = 1'b0; coef_commit = 1'b0;
    wait_out(y, s, lat);
    chk("commit with sample", 16'(y), 16'd6);

    hold = 1'b1;
    accept(8'd100);
    hold = 1'b0;
    quiet("hold no out_valid");
    chk("hold slave_out kept", 16'(slave_out), 16'd6);

    accept(8'd20);
    tick(); tick(); tick();
    clr_pulse();
    chk("midmac clr slave_out", 16'(slave_out), 16'd0);
    chk("midmac clr in_ready", 16'(in_ready), 16'd1);
    quiet("midmac clr no out_valid");
    accept(8'd4);
    wait_out(y, s, lat);
    chk("after clr y", 16'(y), 16'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
